// File: rtl/mx_alu_scheduler.sv
// Round-robin scheduler sharing one MXINT8 ALU among NUM_REQ requesters, one op in flight.
// Optional WAIT watchdog enabled by defining MX_ALU_SCHED_TIMEOUT_EN.
module mx_alu_scheduler #(
   parameter int NUM_REQ = 2,
   parameter int OP_W    = 3,
   parameter int ADDR_W  = 5,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*OP_W-1:0]     req_op,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_src_a,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_src_b,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_dst,
   input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
   output logic                        alu_start,
   output logic [OP_W-1:0]             alu_op,
   output logic [ADDR_W-1:0]           alu_src_a,
   output logic [ADDR_W-1:0]           alu_src_b,
   output logic [ADDR_W-1:0]           alu_dst,
   input  logic                        alu_done,
   input  logic [1:0]                  alu_status,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
   output logic [TAG_W-1:0]            rsp_tag,
   output logic [2:0]                  rsp_status,
   output logic [15:0]                 ops_done
);

   localparam int          ID_W = $clog2(NUM_REQ);
   localparam int unsigned NR   = NUM_REQ;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
      $error("mx_alu_scheduler: parameter out of range");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     gnt_q, gnt_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [ADDR_W-1:0]   src_a_q, src_a_d;
   logic [ADDR_W-1:0]   src_b_q, src_b_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [2:0]          status_q, status_d;
   logic [15:0]         ops_q, ops_d;

`ifdef MX_ALU_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0]     wd_q, wd_d;
`endif

   logic                grant_found;
   logic [ID_W-1:0]     grant_idx;
   logic [ID_W-1:0]     cand;
   int unsigned         rr_idx;
   int unsigned         base;
   logic [OP_W-1:0]     sel_op;
   logic [ADDR_W-1:0]   sel_src_a;
   logic [ADDR_W-1:0]   sel_src_b;
   logic [ADDR_W-1:0]   sel_dst;
   logic [TAG_W-1:0]    sel_tag;

   // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      rr_idx      = '0;
      cand        = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         rr_idx = 32'(rr_ptr_q) + i;
         if (rr_idx >= NR) rr_idx = rr_idx - NR;
         cand = ID_W'(rr_idx);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      base      = 32'(grant_idx);
      sel_op    = req_op[base*OP_W +: OP_W];
      sel_src_a = req_src_a[base*ADDR_W +: ADDR_W];
      sel_src_b = req_src_b[base*ADDR_W +: ADDR_W];
      sel_dst   = req_dst[base*ADDR_W +: ADDR_W];
      sel_tag   = req_tag[base*TAG_W +: TAG_W];
   end

   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && grant_found && !rst) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_d     = gnt_q;
      op_d      = op_q;
      src_a_d   = src_a_q;
      src_b_d   = src_b_q;
      dst_d     = dst_q;
      tag_d     = tag_q;
      status_d  = status_q;
      ops_d     = ops_q;
      alu_start = 1'b0;
      rsp_valid = 1'b0;
`ifdef MX_ALU_SCHED_TIMEOUT_EN
      wd_d      = wd_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               gnt_d    = grant_idx;
               op_d     = sel_op;
               src_a_d  = sel_src_a;
               src_b_d  = sel_src_b;
               dst_d    = sel_dst;
               tag_d    = sel_tag;
               rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            alu_start = !rst;
            state_d   = S_WAIT;
`ifdef MX_ALU_SCHED_TIMEOUT_EN
            wd_d      = '0;
`endif
         end
         S_WAIT: begin
            // A completion arriving in the expiry cycle still reports normal status.
            if (alu_done) begin
               status_d = {1'b0, alu_status};
               state_d  = S_RESP;
            end
`ifdef MX_ALU_SCHED_TIMEOUT_EN
            else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               status_d = 3'b100;
               state_d  = S_RESP;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end
         S_RESP: begin
            rsp_valid = !rst;
            if (rsp_ready) begin
               if (ops_q != 16'hFFFF) ops_d = ops_q + 16'd1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         gnt_q    <= '0;
         op_q     <= '0;
         src_a_q  <= '0;
         src_b_q  <= '0;
         dst_q    <= '0;
         tag_q    <= '0;
         status_q <= '0;
         ops_q    <= '0;
`ifdef MX_ALU_SCHED_TIMEOUT_EN
         wd_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         op_q     <= op_d;
         src_a_q  <= src_a_d;
         src_b_q  <= src_b_d;
         dst_q    <= dst_d;
         tag_q    <= tag_d;
         status_q <= status_d;
         ops_q    <= ops_d;
`ifdef MX_ALU_SCHED_TIMEOUT_EN
         wd_q     <= wd_d;
`endif
      end
   end

   assign alu_op     = op_q;
   assign alu_src_a  = src_a_q;
   assign alu_src_b  = src_b_q;
   assign alu_dst    = dst_q;
   assign rsp_id     = gnt_q;
   assign rsp_tag    = tag_q;
   assign rsp_status = status_q;
   assign ops_done   = ops_q;

endmodule

// File: tb/tb_mx_alu_scheduler.sv
// Scoreboard bench for mx_alu_scheduler: random requesters, a behavioural ALU and an order model.
`timescale 1ns/1ps
module tb_mx_alu_scheduler;
   localparam int NR = 2, OP_W = 3, ADDR_W = 5, TAG_W = 4, TMO = 64;
   localparam int ID_W = $clog2(NR);

   logic                    clk = 1'b0, rst = 1'b1;
   logic [NR-1:0]           req_valid = '0, req_ready;
   logic [NR*OP_W-1:0]      req_op = '0;
   logic [NR*ADDR_W-1:0]    req_src_a = '0, req_src_b = '0, req_dst = '0;
   logic [NR*TAG_W-1:0]     req_tag = '0;
   logic                    alu_start, alu_done = 1'b0;
   logic [OP_W-1:0]         alu_op;
   logic [ADDR_W-1:0]       alu_src_a, alu_src_b, alu_dst;
   logic [1:0]              alu_status = '0;
   logic                    rsp_valid, rsp_ready = 1'b0;
   logic [ID_W-1:0]         rsp_id;
   logic [TAG_W-1:0]        rsp_tag;
   logic [2:0]              rsp_status;
   logic [15:0]             ops_done;

   mx_alu_scheduler #(.NUM_REQ(NR), .OP_W(OP_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_src_a(req_src_a), .req_src_b(req_src_b), .req_dst(req_dst),
      .req_tag(req_tag), .alu_start(alu_start), .alu_op(alu_op), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_dst(alu_dst), .alu_done(alu_done), .alu_status(alu_status),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
      .rsp_status(rsp_status), .ops_done(ops_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] a, b, d;
   } launch_t;
   typedef struct packed {
      logic [7:0]        id;
      logic [TAG_W-1:0]  tag;
   } exp_rsp_t;

   int n_checks = 0, n_fail = 0;

   // requester-side copies of what each requester currently offers
   logic [OP_W-1:0]   p_op [NR];
   logic [ADDR_W-1:0] p_a [NR], p_b [NR], p_d [NR];
   logic [TAG_W-1:0]  p_tag [NR];
   bit                granted [NR];

   launch_t    launch_q[$];
   exp_rsp_t   rsp_q[$];
   logic [2:0] stat_q[$];
   int         id_log[$];
   int         m_ptr = 0, m_ops = 0;
   bit         m_busy = 0, in_flight = 0;
   launch_t    cur;

   int mode = 4, rsp_mode = 1;
   bit single_arm = 0, hang_arm = 0, alu_hang = 0, spur_en = 0;
   int alu_lat_fix = -1, alu_st_fix = -1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: model grant order, launches and responses.
   always @(negedge clk) begin
      int g;
      logic [NR-1:0] exp_rdy;
      launch_t l;
      if (rst) begin
         launch_q.delete(); rsp_q.delete(); stat_q.delete();
         m_ptr = 0; m_busy = 0; in_flight = 0;
         m_ops = 0;
      end else begin
         chk("ops_done", ops_done, m_ops);
         g = -1;
         if (!m_busy)
            for (int k = 0; k < NR; k++)
               if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         chk("req_ready", req_ready, exp_rdy);
         if (g >= 0) begin
            m_ptr = (g + 1) % NR;
            m_busy = 1;
            granted[g] = 1;
            launch_q.push_back('{op: p_op[g], a: p_a[g], b: p_b[g], d: p_d[g]});
            rsp_q.push_back('{id: 8'(g), tag: p_tag[g]});
         end
         if (alu_start) begin
            chk("alu_start_expected", launch_q.size() > 0, 1);
            if (launch_q.size() > 0) begin
               l = launch_q.pop_front();
               chk("alu_launch", {alu_op, alu_src_a, alu_src_b, alu_dst}, l);
               cur = l;
               in_flight = 1;
            end
         end else if (in_flight) begin
            chk("alu_hold", {alu_op, alu_src_a, alu_src_b, alu_dst}, cur);
         end
         if (rsp_valid) begin
            in_flight = 0;
            chk("rsp_expected", rsp_q.size() > 0 && stat_q.size() > 0, 1);
            if (rsp_q.size() > 0 && stat_q.size() > 0) begin
               chk("rsp_id", rsp_id, rsp_q[0].id);
               chk("rsp_tag", rsp_tag, rsp_q[0].tag);
               chk("rsp_status", rsp_status, stat_q[0]);
               if (rsp_ready) begin
                  id_log.push_back(int'(rsp_q[0].id));
                  void'(rsp_q.pop_front());
                  void'(stat_q.pop_front());
                  m_busy = 0;
                  if (m_ops < 16'hFFFF) m_ops++;
               end
            end
         end
      end
   end

   // Behavioural ALU: random latency/status, optional hang, spurious completions when idle.
   always @(negedge clk) begin
      static bit a_busy = 0;
      static int a_cnt = 0;
      static logic [1:0] a_st = '0;
      alu_done = 1'b0;
      if (rst) begin
         a_busy = 0;
      end else if (a_busy) begin
         if (a_cnt == 0) begin
            alu_done = 1'b1;
            alu_status = a_st;
            stat_q.push_back({1'b0, a_st});
            a_busy = 0;
         end else a_cnt--;
      end else if (alu_start) begin
         if (alu_hang) begin
`ifdef MX_ALU_SCHED_TIMEOUT_EN
            stat_q.push_back(3'b100);
`endif
         end else begin
            a_busy = 1;
            a_cnt = (alu_lat_fix >= 0) ? alu_lat_fix : int'($urandom_range(0, 5));
            a_st = (alu_st_fix >= 0) ? 2'(alu_st_fix) : 2'($urandom);
         end
      end else if (spur_en && $urandom_range(0, 4) == 0) begin
         alu_done = 1'b1;
         alu_status = 2'($urandom);
      end
   end

   task automatic raise(input int i, input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag);
      p_op[i] = op; p_tag[i] = tag;
      p_a[i] = ADDR_W'($urandom); p_b[i] = ADDR_W'($urandom); p_d[i] = ADDR_W'($urandom);
      req_op[i*OP_W +: OP_W] = op;
      req_tag[i*TAG_W +: TAG_W] = tag;
      req_src_a[i*ADDR_W +: ADDR_W] = p_a[i];
      req_src_b[i*ADDR_W +: ADDR_W] = p_b[i];
      req_dst[i*ADDR_W +: ADDR_W] = p_d[i];
      req_valid[i] = 1'b1;
   endtask

   task automatic step();
      bit go;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
         if (granted[i]) begin req_valid[i] = 1'b0; granted[i] = 0; end
         if (!req_valid[i]) begin
            case (mode)
               0: go = ($urandom_range(0, 2) == 0);
               1: go = (i == 0) && single_arm;
               2: go = 1;
               3: go = (i == 0) && hang_arm;
               default: go = 0;
            endcase
            if (go) begin
               if (mode == 1) begin raise(i, '0, 4'd5); single_arm = 0; end
               else begin raise(i, OP_W'($urandom), TAG_W'($urandom)); if (mode == 3) hang_arm = 0; end
            end
         end
      end
      case (rsp_mode)
         0: rsp_ready = ($urandom_range(0, 3) != 0);
         1: rsp_ready = 1'b1;
         default: rsp_ready = 1'b0;
      endcase
   endtask

   task automatic check_reset_outputs();
      chk("rst_req_ready", req_ready, '0);
      chk("rst_alu_start", alu_start, 0);
      chk("rst_alu_fields", {alu_op, alu_src_a, alu_src_b, alu_dst}, '0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, '0);
      chk("rst_rsp_tag", rsp_tag, '0);
      chk("rst_rsp_status", rsp_status, '0);
      chk("rst_ops_done", ops_done, '0);
   endtask

   task automatic pulse_reset(input bit check);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      if (check) check_reset_outputs();
      rst = 1'b0;
   endtask

   task automatic drain();
      int k;
      mode = 4;
      for (k = 0; k < 400 && (req_valid != '0 || m_busy); k++) step();
      chk("drain_in_time", req_valid == '0 && !m_busy, 1);
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
   end

   initial begin
      int k, ops0;
      repeat (3) step();
      check_reset_outputs();
      rst = 1'b0;

      // spurious completions while idle
      spur_en = 1; mode = 4;
      repeat (12) step();
      chk("spurious_no_rsp", rsp_valid, 0);
      chk("spurious_ops", ops_done, 16'd0);
      spur_en = 0;

      // single request, fixed latency, clean status
      alu_lat_fix = 2; alu_st_fix = 0; single_arm = 1; mode = 1;
      for (k = 0; k < 60 && m_ops < 1; k++) step();
      step();
      chk("single_ops_done", ops_done, 16'd1);
      chk("single_rsp_id", id_log.size() > 0 ? id_log[0] : -1, 0);

      // scale-overflow flag propagates
      alu_st_fix = 2; single_arm = 1;
      for (k = 0; k < 60 && m_ops < 2; k++) step();
      step();
      chk("status_ops_done", ops_done, 16'd2);
      alu_st_fix = -1; alu_lat_fix = -1;
      drain();

      // contention from reset
      pulse_reset(0);
      id_log.delete(); mode = 2;
      for (k = 0; k < 200 && id_log.size() < 4; k++) step();
      chk("contention_count", id_log.size() >= 4, 1);
      for (int i = 0; i < 4; i++) chk("contention_order", i < id_log.size() ? id_log[i] : -1, i % 2);
      drain();

      // response backpressure with other requesters active
      mode = 0; rsp_mode = 2;
      for (k = 0; k < 100 && !rsp_valid; k++) step();
      chk("bp_rsp_valid", rsp_valid, 1);
      ops0 = int'(ops_done);
      repeat (12) step();
      chk("bp_ops_held", ops_done, ops0);
      chk("bp_still_valid", rsp_valid, 1);
      rsp_mode = 1;
      step();
      step();
      chk("bp_ops_inc", ops_done, ops0 + 1);

      // random traffic
      rsp_mode = 0; spur_en = 1;
      repeat (600) step();
      rsp_mode = 1;
      drain();

      // reset in WAIT abandons the op
      mode = 0;
      for (k = 0; k < 100 && !(in_flight && !rsp_valid); k++) step();
      chk("midreset_in_wait", in_flight, 1);
      pulse_reset(1);
      repeat (150) step();
      drain();

      // ALU never completes
      spur_en = 0; alu_hang = 1; hang_arm = 1; mode = 3; rsp_mode = 1;
      ops0 = int'(ops_done);
`ifdef MX_ALU_SCHED_TIMEOUT_EN
      for (k = 0; k < TMO + 60 && m_ops <= ops0; k++) step();
      step();
      chk("timeout_rsp", ops_done, ops0 + 1);
      alu_hang = 0;
`else
      repeat (1000) step();
      chk("hang_no_rsp", rsp_valid, 0);
      chk("hang_ops_held", ops_done, ops0);
      chk("hang_in_flight", in_flight, 1);
      alu_hang = 0;
      pulse_reset(1);
`endif
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mx_alu_scheduler.md
MX_ALU_SCHEDULER -- requirements
Module: mx_alu_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing the MXINT8 ALU (2..8).
REQ-002 Parameter OP_W, default 3: opcode width (negate, add, sub, scale-mul, fp32-to-scale, ...).
REQ-003 Parameter ADDR_W, default 5: operand/destination vector-register index width.
REQ-004 Parameter TAG_W, default 4: requester-supplied transaction tag width.
REQ-005 Parameter TIMEOUT, default 64: WAIT-state watchdog limit in cycles; used only with the macro in REQ-030.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 req_valid  input  NUM_REQ  per-requester request valid.
REQ-009 req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-010 req_op / req_src_a / req_src_b / req_dst / req_tag  input  NUM_REQ*{OP_W,ADDR_W,ADDR_W,ADDR_W,TAG_W}  packed per-requester fields, requester i at slice i.
REQ-011 alu_start  output  1  one-cycle ALU launch pulse.
REQ-012 alu_op, alu_src_a, alu_src_b, alu_dst  output  OP_W, ADDR_W, ADDR_W, ADDR_W  launched operation.
REQ-013 alu_done  input  1  ALU completion pulse.
REQ-014 alu_status  input  2  completion flags, bit0 NaN/unused-code result, bit1 scale overflow.
REQ-015 rsp_valid  output  1, rsp_ready  input  1: response handshake.
REQ-016 rsp_id  output  $clog2(NUM_REQ), rsp_tag  output  TAG_W, rsp_status  output  3: response fields.
REQ-017 ops_done  output  16  completed-operation counter.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP; exactly one operation in flight.
REQ-019 IDLE: when any req_valid is high, grant round-robin starting at rr_ptr; assert req_ready[g] combinationally the same cycle, latch op/src/dst/tag and g, set rr_ptr to (g+1) mod NUM_REQ, go ISSUE.
REQ-020 req_ready SHALL be all zero outside IDLE and when no req_valid is high.
REQ-021 ISSUE: alu_start=1 for exactly one cycle; go WAIT.
REQ-022 alu_op/src/dst SHALL hold the latched values from ISSUE through WAIT; alu_start=0 in all other states.
REQ-023 WAIT: on alu_done, capture {1'b0, alu_status} into rsp_status, go RESP; alu_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-024 RESP: rsp_valid=1 with rsp_id=g and rsp_tag/rsp_status stable until rsp_ready; on rsp_valid&&rsp_ready increment ops_done and go IDLE.
REQ-025 ops_done SHALL saturate at 16'hFFFF.
REQ-026 Minimum throughput: one operation per 4 cycles plus ALU latency; a new grant is possible in the cycle after the RESP handshake.
REQ-027 A requester holding req_valid SHALL be granted within NUM_REQ grants (starvation-free).

Reset
REQ-028 While rst is high: state=IDLE, rr_ptr=0, req_ready=0, alu_start=0, alu_op/src/dst=0, rsp_valid=0, rsp_id/tag/status=0, ops_done=0, watchdog=0.
REQ-029 rst asserted mid-operation SHALL abandon the operation with no response; the ALU shares rst and is reset with it.

Configuration
REQ-030 Macro MX_ALU_SCHED_TIMEOUT_EN defined: a counter clears on entering WAIT and increments each WAIT cycle; on reaching TIMEOUT without alu_done go RESP with rsp_status=3'b100; alu_done in the same cycle as expiry takes priority (normal status).
REQ-031 Macro undefined: no counter, WAIT persists until alu_done, rsp_status[2] constant 0.

Verification
REQ-032 Single request: req_valid=01, op=negate, tag=5, ALU done 3 cycles after start, status 00 -> alu_start one cycle, rsp_id=0, tag=5, status=000, ops_done=1.
REQ-033 Contention: both requesters valid continuously after reset -> grants 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-034 Response backpressure: rsp_ready low 10 cycles -> rsp fields stable, req_ready all zero, ops_done unchanged until handshake.
REQ-035 Status flags: alu_status=10 on done -> rsp_status=010; spurious alu_done in IDLE -> no state change.
REQ-036 With MX_ALU_SCHED_TIMEOUT_EN, TIMEOUT=8, alu_done never asserted -> rsp_status=100 after 8 WAIT cycles; without macro -> still in WAIT after 1000 cycles.
REQ-037 rst pulsed in WAIT -> next cycle all outputs at reset values, rr_ptr=0, no response emitted.
